logic_unit_pipe: RTL
====================

Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the team's single-bit AND/OR/NOT gate block.
- Performs one of eight bitwise operations on WIDTH-bit operands.
- Optional accumulate mode folds each result into an internal accumulator.
- Two-stage valid/ready pipeline with full backpressure; sits between operand producers and any downstream consumer in the datapath test fabric.

Parameters:
- WIDTH, 8, operand/result width in bits (1..64).
- ACC_INIT, 0, accumulator value after reset and after acc_clear (WIDTH bits).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  WIDTH  operand A; ignored when in_acc=1.
- in_b  in  WIDTH  operand B.
- in_op  in  3  opcode: 0 AND, 1 OR, 2 NOT A, 3 XOR, 4 NAND, 5 NOR, 6 XNOR, 7 PASS B.
- in_acc  in  1  accumulate: A := accumulator; result written back to accumulator.
- acc_clear  in  1  load accumulator with ACC_INIT (single-cycle pulse).
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result.
- out_y  out  WIDTH  result.
- out_zero  out  1  out_y == 0.
- out_parity  out  1  XOR-reduction of out_y.
- acc_value  out  WIDTH  current accumulator contents.

Behaviour:
- Reset (async, rst=1): both stage valids clear. out_valid=0, out_y=0, out_zero=1, out_parity=0, acc_value=ACC_INIT, in_ready=1 once rst deasserts.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_valid, once high, holds its data until accepted; the same rule applies to out_valid.
- Stage 1 (S1): registers op result = f(in_op, A, B), where A = in_acc ? accumulator : in_a.
- Stage 2 (S2): registers S1 result and computes out_zero and out_parity from it. Outputs are driven directly from S2 registers.
- Latency: accepted beat appears on out_y exactly 2 cycles later when unstalled. Throughput is 1 beat/cycle.
- Ready chain:
  - s2_ready = ~s2_valid | out_ready.
  - s1_ready = ~s1_valid | s2_ready.
  - in_ready = s1_ready.
  - No combinational path from in_valid to in_ready.
- Stall: with out_ready=0, S2 holds. S1 holds once full. in_ready drops after two beats are buffered. No beat is lost or duplicated.
- Accumulator:
  - Updated at the S1 capture edge for accepted beats with in_acc=1.
  - Back-to-back accumulate beats therefore see each previous result with no bubble.
  - Beats with in_acc=0 never modify the accumulator.
- acc_clear priority:
  - An accepted accumulate beat in the same cycle uses ACC_INIT as A and writes its result.
  - A same-cycle non-accumulate beat leaves the accumulator = ACC_INIT.
  - acc_clear is legal while stalled.
- NOT A ignores in_b. PASS B ignores A and does not change the accumulator value unless in_acc=1, in which case the accumulator := in_b.
- All arithmetic is bitwise, WIDTH bits, with no carries.
- Reset mid-stream discards all in-flight beats immediately. The accumulator returns to ACC_INIT.

Decomposition:
- Package logic_unit_pkg holds:
  - opcode enum (OP_AND..OP_PASSB, 3 bits);
  - OP_W=3;
  - function logic_op(op, a, b) returning the WIDTH-bit result.
- One combinational sub-module, logic_unit_core (opcode decode + op), instantiated in S1.
- Flag generation stays inline in the top.

Test Plan (WIDTH=8, ACC_INIT=0):
- Truth sweep: apply all 8 opcodes with a=8'hF0, b=8'hCC, out_ready=1 -> results 8'hC0, FC, 0F, 3C, 3F, 03, C3, CC, each 2 cycles after acceptance. Flags match (e.g. XOR 3C: zero=0, parity=0).
- Backpressure: stream 5 XOR beats while out_ready=0 -> in_ready falls after 2 accepted beats. Release out_ready -> all 5 results arrive in order with none dropped.
- Accumulate chain: acc_clear, then OR beats b=01,02,04,08 with in_acc=1 back-to-back -> out_y 01,03,07,0F and acc_value=8'h0F.
- Clear collision: acc_value=8'h0F, then XOR with in_acc=1, b=8'hFF in the same cycle as acc_clear -> out_y=8'hFF and acc_value=8'hFF.
- Zero flag: AND with a=8'hAA, b=8'h55 -> out_y=0, out_zero=1, out_parity=0.
- Async reset: assert rst mid-stream with 2 beats in flight and accumulator=8'h3C -> out_valid=0 and acc_value=8'h00 without waiting for a clk edge. The first beat after release returns with 2-cycle latency.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared opcode encoding and bitwise operation helper
// for the pipelined logic unit.
package logic_unit_pkg;

  localparam int OP_W  = 3;
  localparam int MAX_W = 64;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_NOTA  = 3'd2,
    OP_XOR   = 3'd3,
    OP_NAND  = 3'd4,
    OP_NOR   = 3'd5,
    OP_XNOR  = 3'd6,
    OP_PASSB = 3'd7
  } op_e;

  // Operates at the widest legal width; callers truncate.
  function automatic logic [MAX_W-1:0] logic_op(
    input op_e              op,
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b
  );
    logic [MAX_W-1:0] r;
    case (op)
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_NOTA:  r = ~a;
      OP_XOR:   r = a ^ b;
      OP_NAND:  r = ~(a & b);
      OP_NOR:   r = ~(a | b);
      OP_XNOR:  r = ~(a ^ b);
      OP_PASSB: r = b;
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_core.sv
// Combinational opcode decode and bitwise op,
// evaluated in front of the first pipeline register.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  logic [MAX_W-1:0] r;

  assign r   = logic_op(op_i, MAX_W'(a_i), MAX_W'(b_i));
  assign y_o = r[WIDTH-1:0];

  if (WIDTH < MAX_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^r[MAX_W-1:WIDTH];
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit with an
// optional accumulator fed back as operand A.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  input  logic             in_acc,
  input  logic             acc_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_parity,
  output logic [WIDTH-1:0] acc_value
);

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_y_q;
  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_y_q;
  logic             zero_q;
  logic             par_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;

  logic             s1_ready;
  logic             s2_ready;
  logic             in_fire;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] y_core;

  assign s2_ready = ~s2_valid_q | out_ready;
  assign s1_ready = ~s1_valid_q | s2_ready;
  assign in_ready = s1_ready;
  assign in_fire  = in_valid & s1_ready;

  // A clear in the same cycle wins over the stored value.
  always_comb begin
    a_sel = in_a;
    if (in_acc) begin
      a_sel = acc_clear ? ACC_INIT : acc_q;
    end
  end

  logic_unit_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op_i(op_e'(in_op)),
    .a_i (a_sel),
    .b_i (in_b),
    .y_o (y_core)
  );

  always_comb begin
    acc_d = acc_q;
    if (acc_clear) begin
      acc_d = ACC_INIT;
    end
    if (in_fire && in_acc) begin
      acc_d = y_core;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= ACC_INIT;
    end else begin
      acc_q <= acc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_y_q     <= '0;
    end else if (s1_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_y_q <= y_core;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_y_q     <= '0;
      zero_q     <= 1'b1;
      par_q      <= 1'b0;
    end else if (s2_ready) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_y_q <= s1_y_q;
        zero_q <= ~|s1_y_q;
        par_q  <= ^s1_y_q;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_y      = s2_y_q;
  assign out_zero   = zero_q;
  assign out_parity = par_q;
  assign acc_value  = acc_q;

endmodule
